// File: rtl/beta_dmem_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
package beta_dmem_arbiter_pkg;

  localparam int arb_fsm_bsize = 2;

  typedef enum logic [arb_fsm_bsize-1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/beta_dmem_arbiter_if.sv
// Requester-side and memory-side buses of the data-memory arbiter.
interface beta_dmem_arbiter_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int NumMasters   = 3
);

  logic [NumMasters-1:0]              m_req_i;
  logic [NumMasters-1:0]              m_we_i;
  logic [NumMasters*AddressWidth-1:0] m_addr_i;
  logic [NumMasters*DataWidth/8-1:0]  m_strb_i;
  logic [NumMasters*DataWidth-1:0]    m_wdata_i;
  logic [NumMasters-1:0]              m_ready_o;
  logic [NumMasters-1:0]              m_valid_o;
  logic                               m_err_o;
  logic [DataWidth-1:0]               m_rdata_o;

  logic                               mem_req_o;
  logic                               mem_we_o;
  logic [AddressWidth-1:0]            mem_addr_o;
  logic [DataWidth/8-1:0]             mem_strb_o;
  logic [DataWidth-1:0]               mem_wdata_o;
  logic                               mem_ready_i;
  logic                               mem_valid_i;
  logic [DataWidth-1:0]               mem_rdata_i;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_strb_i, m_wdata_i,
    input  mem_ready_i, mem_valid_i, mem_rdata_i,
    output m_ready_o, m_valid_o, m_err_o, m_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_strb_i, m_wdata_i,
    output mem_ready_i, mem_valid_i, mem_rdata_i,
    input  m_ready_o, m_valid_o, m_err_o, m_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o
  );

endinterface

// File: rtl/beta_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module beta_rr_arbiter #(
  parameter int  NumMasters = 3,
  localparam int IdxWidth   = $clog2(NumMasters)
) (
  input  logic [NumMasters-1:0] req,
  input  logic [IdxWidth-1:0]   ptr,
  output logic [IdxWidth-1:0]   winner,
  output logic                  req_any
);

  always_comb begin
    int idx;
    winner  = '0;
    req_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < NumMasters; i++) begin
      idx = (int'(ptr) + i) % NumMasters;
      if (!req_any && req[idx]) begin
        req_any = 1'b1;
        winner  = IdxWidth'(idx);
      end
    end
  end

endmodule

// File: rtl/beta_dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port, with a response watchdog
// that completes a stalled transaction with an error flag.
module beta_dmem_arbiter
  import beta_dmem_arbiter_pkg::*;
#(
  parameter int  DataWidth     = 32,
  parameter int  AddressWidth  = 32,
  parameter int  NumMasters    = 3,
  parameter int  TimeoutCycles = 256,
  localparam int GrantWidth    = $clog2(NumMasters)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  beta_dmem_arbiter_if.slave    bus,
  output logic                  busy_o,
  output logic [GrantWidth-1:0] grant_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int WdogWidth = $clog2(TimeoutCycles);
  localparam logic [WdogWidth-1:0]  WdogLast   = WdogWidth'(TimeoutCycles - 1);
  localparam logic [GrantWidth-1:0] LastMaster = GrantWidth'(NumMasters - 1);

  arb_state_e              state;
  logic [GrantWidth-1:0]   grant;
  logic [GrantWidth-1:0]   rr_ptr;
  logic [GrantWidth-1:0]   winner;
  logic [GrantWidth-1:0]   grant_next;
  logic                    req_any;
  logic [WdogWidth-1:0]    wdog;
  logic                    we_q;
  logic [AddressWidth-1:0] addr_q;
  logic [StrbWidth-1:0]    strb_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [NumMasters-1:0]   valid_q;
  logic                    err_q;
  logic [DataWidth-1:0]    rdata_q;
  logic [NumMasters-1:0]   grant_onehot;
  logic [AddressWidth-1:0] win_addr;
  logic [StrbWidth-1:0]    win_strb;
  logic [DataWidth-1:0]    win_wdata;

  beta_rr_arbiter #(.NumMasters(NumMasters)) u_rr (
    .req     (bus.m_req_i),
    .ptr     (rr_ptr),
    .winner  (winner),
    .req_any (req_any)
  );

  assign win_addr     = bus.m_addr_i[int'(winner)*AddressWidth +: AddressWidth];
  assign win_strb     = bus.m_strb_i[int'(winner)*StrbWidth +: StrbWidth];
  assign win_wdata    = bus.m_wdata_i[int'(winner)*DataWidth +: DataWidth];
  assign grant_onehot = NumMasters'(1) << grant;
  assign grant_next   = (grant == LastMaster) ? '0 : grant + GrantWidth'(1);

  assign bus.mem_req_o   = (state == ARB_REQ);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_strb_o  = strb_q;
  assign bus.mem_wdata_o = wdata_q;
  // Accept is a same-cycle pass-through of the memory's ready to the granted master.
  assign bus.m_ready_o   = (state == ARB_REQ && bus.mem_ready_i) ? grant_onehot : '0;
  assign bus.m_valid_o   = valid_q;
  assign bus.m_err_o     = err_q;
  assign bus.m_rdata_o   = rdata_q;
  assign busy_o          = (state != ARB_IDLE);
  assign grant_o         = grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ARB_IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      wdog    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= '0;
      err_q   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (req_any) begin
            grant   <= winner;
            we_q    <= bus.m_we_i[winner];
            addr_q  <= win_addr;
            strb_q  <= win_strb;
            wdata_q <= win_wdata;
            state   <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus.mem_ready_i) begin
            wdog  <= '0;
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          // A real response beats a coincident watchdog expiry.
          if (bus.mem_valid_i) begin
            valid_q <= grant_onehot;
            if (!we_q) rdata_q <= bus.mem_rdata_i;
            rr_ptr  <= grant_next;
            state   <= ARB_IDLE;
          end else if (wdog == WdogLast) begin
            valid_q <= grant_onehot;
            err_q   <= 1'b1;
            rr_ptr  <= grant_next;
            state   <= ARB_IDLE;
          end else begin
            wdog <= wdog + WdogWidth'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
